// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH pipeline register slices carrying a control and a data bundle,
// with per-slice stall/flush, bubble insertion, backpressure and a saturating bubble counter.
module pipe_stage_chain #(
  parameter int DEPTH      = 1,
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 32,
  parameter bit FLUSH_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEPTH-1:0]  stall_i,
  input  logic [DEPTH-1:0]  flush_i,
  input  logic              clr_cnt,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEPTH-1:0]  slice_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [DEPTH-1:0]  valid_q;
  logic [CTRL_W-1:0] ctrl_q   [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0]  stall_eff;
  logic [DEPTH-1:0]  src_valid;
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];
  logic              last_bubble;

  // A held slice holds everything upstream of it.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stall_eff[k] = |(stall_i >> k);
    end
  end

  assign src_valid[0] = in_valid;
  assign src_ctrl[0]  = in_ctrl;
  assign src_data[0]  = in_data;

  // An upstream slice that is itself held forwards a bubble, never a copy.
  for (genvar k = 1; k < DEPTH; k++) begin : g_src
    assign src_valid[k] = valid_q[k-1] & ~stall_eff[k-1];
    assign src_ctrl[k]  = ctrl_q[k-1];
    assign src_data[k]  = data_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush_i[k]) begin
          valid_q[k] <= 1'b0;
          ctrl_q[k]  <= '0;
          if (FLUSH_DATA) data_q[k] <= '0;
        end else if (!stall_eff[k]) begin
          valid_q[k] <= src_valid[k];
          ctrl_q[k]  <= src_valid[k] ? src_ctrl[k] : '0;
          data_q[k]  <= src_data[k];
        end
      end
    end
  end

  assign last_bubble = flush_i[DEPTH-1] | (~stall_eff[DEPTH-1] & ~src_valid[DEPTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
    end else if (last_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  // ctrl is already zero whenever valid is zero, so no output gating.
  assign in_ready    = ~stall_eff[0];
  assign out_valid   = valid_q[DEPTH-1];
  assign out_ctrl    = ctrl_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign slice_valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: DEPTH=3 streaming/stall/reset, DEPTH=2 flush with both
// FLUSH_DATA settings, DEPTH=1 with a 2-bit saturating bubble counter.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // DEPTH=3 instance
  logic        d3_in_valid = 1'b0;
  logic [7:0]  d3_in_ctrl = '0;
  logic [31:0] d3_in_data = '0;
  logic [2:0]  d3_stall = '0, d3_flush = '0;
  logic        d3_clr = 1'b0;
  logic        d3_in_ready, d3_out_valid;
  logic [7:0]  d3_out_ctrl;
  logic [31:0] d3_out_data;
  logic [2:0]  d3_slice_valid;
  logic [15:0] d3_bubble_cnt;

  // DEPTH=2 instances share inputs, differ in FLUSH_DATA
  logic        d2_in_valid = 1'b0;
  logic [7:0]  d2_in_ctrl = '0;
  logic [31:0] d2_in_data = '0;
  logic [1:0]  d2_stall = '0, d2_flush = '0;
  logic        d2a_in_ready, d2a_out_valid, d2b_in_ready, d2b_out_valid;
  logic [7:0]  d2a_out_ctrl, d2b_out_ctrl;
  logic [31:0] d2a_out_data, d2b_out_data;
  logic [1:0]  d2a_slice_valid, d2b_slice_valid;
  logic [15:0] d2a_bubble_cnt, d2b_bubble_cnt;

  // DEPTH=1, CNT_W=2 instance
  logic        d1_in_valid = 1'b0;
  logic [7:0]  d1_in_ctrl = '0;
  logic [31:0] d1_in_data = '0;
  logic [0:0]  d1_stall = '0, d1_flush = '0;
  logic        d1_clr = 1'b0;
  logic        d1_in_ready, d1_out_valid;
  logic [7:0]  d1_out_ctrl;
  logic [31:0] d1_out_data;
  logic [0:0]  d1_slice_valid;
  logic [1:0]  d1_bubble_cnt;

  pipe_stage_chain #(.DEPTH(3), .CTRL_W(8), .DATA_W(32), .FLUSH_DATA(1'b1), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(d3_in_valid), .in_ctrl(d3_in_ctrl), .in_data(d3_in_data),
    .stall_i(d3_stall), .flush_i(d3_flush), .clr_cnt(d3_clr), .in_ready(d3_in_ready),
    .out_valid(d3_out_valid), .out_ctrl(d3_out_ctrl), .out_data(d3_out_data),
    .slice_valid(d3_slice_valid), .bubble_cnt(d3_bubble_cnt));

  pipe_stage_chain #(.DEPTH(2), .CTRL_W(8), .DATA_W(32), .FLUSH_DATA(1'b1), .CNT_W(16)) u_d2a (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ctrl(d2_in_ctrl), .in_data(d2_in_data),
    .stall_i(d2_stall), .flush_i(d2_flush), .clr_cnt(1'b0), .in_ready(d2a_in_ready),
    .out_valid(d2a_out_valid), .out_ctrl(d2a_out_ctrl), .out_data(d2a_out_data),
    .slice_valid(d2a_slice_valid), .bubble_cnt(d2a_bubble_cnt));

  pipe_stage_chain #(.DEPTH(2), .CTRL_W(8), .DATA_W(32), .FLUSH_DATA(1'b0), .CNT_W(16)) u_d2b (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ctrl(d2_in_ctrl), .in_data(d2_in_data),
    .stall_i(d2_stall), .flush_i(d2_flush), .clr_cnt(1'b0), .in_ready(d2b_in_ready),
    .out_valid(d2b_out_valid), .out_ctrl(d2b_out_ctrl), .out_data(d2b_out_data),
    .slice_valid(d2b_slice_valid), .bubble_cnt(d2b_bubble_cnt));

  pipe_stage_chain #(.DEPTH(1), .CTRL_W(8), .DATA_W(32), .FLUSH_DATA(1'b1), .CNT_W(2)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ctrl(d1_in_ctrl), .in_data(d1_in_data),
    .stall_i(d1_stall), .flush_i(d1_flush), .clr_cnt(d1_clr), .in_ready(d1_in_ready),
    .out_valid(d1_out_valid), .out_ctrl(d1_out_ctrl), .out_data(d1_out_data),
    .slice_valid(d1_slice_valid), .bubble_cnt(d1_bubble_cnt));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int next_e;
    logic [31:0] exp_d;
    logic exp_ov;

    // Reset state
    #1;
    check("rst_out_valid", d3_out_valid, 1'b0);
    check("rst_slice_valid", d3_slice_valid, 3'b000);
    check("rst_bubble_cnt", d3_bubble_cnt, 16'd0);
    check("rst_out_data", d3_out_data, 32'd0);
    check("rst_in_ready", d3_in_ready, 1'b1);
    repeat (2) step();
    rst = 1'b0;

    // 1: streaming 1..5 through DEPTH=3, first output after 3 edges
    for (int i = 1; i <= 7; i++) begin
      d3_in_valid = (i <= 5);
      d3_in_data  = i;
      d3_in_ctrl  = 8'h10 + 8'(i);
      d3_clr      = (i <= 2);
      step();
      if (i >= 3) begin
        check("t1_out_valid", d3_out_valid, 1'b1);
        check("t1_out_data", d3_out_data, 64'(i - 2));
        check("t1_out_ctrl", d3_out_ctrl, 8'h10 + 8'(i - 2));
      end else begin
        check("t1_fill_valid", d3_out_valid, 1'b0);
      end
    end
    d3_clr = 1'b0;
    check("t1_bubble_cnt", d3_bubble_cnt, 16'd0);

    // 2: mid-chain stall on slice 1 for two cycles, scoreboard checks order
    next_e = 10;
    for (int c = 0; c <= 9; c++) begin
      d3_stall    = (c == 3 || c == 4) ? 3'b010 : 3'b000;
      d3_clr      = (c < 2);
      d3_in_valid = (next_e <= 15);
      d3_in_data  = next_e;
      d3_in_ctrl  = 8'(next_e) ^ 8'hA5;
      #1;
      check("t2_in_ready", d3_in_ready, (d3_stall == 3'b000));
      if (d3_in_valid && d3_stall == 3'b000) begin
        exp_q.push_back(32'(next_e));
        next_e++;
      end
      @(posedge clk);
      #1;
      exp_ov = (c == 2) || (c >= 5);
      check("t2_out_valid", d3_out_valid, exp_ov);
      if (exp_ov) begin
        if (exp_q.size() == 0) begin
          check("t2_queue_empty", 1'b1, 1'b0);
        end else begin
          exp_d = exp_q.pop_front();
          check("t2_out_data", d3_out_data, exp_d);
          check("t2_out_ctrl", d3_out_ctrl, exp_d[7:0] ^ 8'hA5);
        end
      end else begin
        check("t2_bubble_ctrl", d3_out_ctrl, 8'h00);
      end
      if (c == 3) check("t2_slice_valid_stall", d3_slice_valid, 3'b011);
    end
    d3_clr = 1'b0;
    d3_stall = '0;
    d3_in_valid = 1'b0;
    check("t2_bubble_cnt", d3_bubble_cnt, 16'd2);
    check("t2_queue_drained", exp_q.size(), 0);

    // 3: DEPTH=2 flush+stall on slice 0, then stall persists
    d2_in_valid = 1'b1; d2_in_data = 32'hAB; d2_in_ctrl = 8'h5A;
    step();
    check("t3_load_sv", d2a_slice_valid, 2'b01);
    d2_in_data = 32'hCD; d2_in_ctrl = 8'h3C; d2_stall = 2'b01; d2_flush = 2'b01;
    #1;
    check("t3_in_ready", d2a_in_ready, 1'b0);
    step();
    check("t3_flush_sv_a", d2a_slice_valid, 2'b00);
    check("t3_flush_sv_b", d2b_slice_valid, 2'b00);
    check("t3_flush_out_data", d2a_out_data, 32'hAB);
    check("t3_flush_out_ctrl", d2a_out_ctrl, 8'h00);
    d2_flush = 2'b00;
    step();
    check("t3_hold_sv_a", d2a_slice_valid, 2'b00);
    check("t3_hold_data_fd1", d2a_out_data, 32'h0);
    check("t3_hold_data_fd0", d2b_out_data, 32'hAB);
    d2_stall = 2'b00;
    step();
    check("t3_accept_sv", d2a_slice_valid, 2'b01);
    check("t3_bubble_data_fd1", d2a_out_data, 32'h0);
    check("t3_bubble_data_fd0", d2b_out_data, 32'hAB);
    d2_in_valid = 1'b0; d2_in_data = '0; d2_in_ctrl = '0;
    step();
    check("t3_out_valid_a", d2a_out_valid, 1'b1);
    check("t3_out_data_a", d2a_out_data, 32'hCD);
    check("t3_out_ctrl_b", d2b_out_ctrl, 8'h3C);
    check("t3_out_data_b", d2b_out_data, 32'hCD);

    // 6 + 4: DEPTH=1 bubble zeroes ctrl, stall holds, counter saturates at 3
    d1_clr = 1'b1; d1_in_valid = 1'b0; d1_in_ctrl = 8'hFF; d1_in_data = 32'h12;
    step();
    check("t6_bubble_valid", d1_out_valid, 1'b0);
    check("t6_bubble_ctrl", d1_out_ctrl, 8'h00);
    check("t6_bubble_data", d1_out_data, 32'h12);
    check("t6_cnt_clr", d1_bubble_cnt, 2'd0);
    d1_clr = 1'b0; d1_in_valid = 1'b1; d1_in_data = 32'h34; d1_in_ctrl = 8'h09;
    step();
    check("t6_load_valid", d1_out_valid, 1'b1);
    check("t6_load_data", d1_out_data, 32'h34);
    check("t6_load_ctrl", d1_out_ctrl, 8'h09);
    d1_stall = 1'b1; d1_in_data = 32'h56; d1_in_ctrl = 8'h77;
    #1;
    check("t6_in_ready", d1_in_ready, 1'b0);
    step();
    check("t6_hold_data", d1_out_data, 32'h34);
    check("t6_hold_ctrl", d1_out_ctrl, 8'h09);
    check("t6_hold_cnt", d1_bubble_cnt, 2'd0);
    d1_stall = 1'b0; d1_in_valid = 1'b0; d1_in_ctrl = 8'hFF;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("t4_cnt_sat", d1_bubble_cnt, (i < 3) ? 2'(i) : 2'd3);
    end
    d1_clr = 1'b1;
    step();
    check("t4_clr_priority", d1_bubble_cnt, 2'd0);
    d1_clr = 1'b0;

    // 5: async reset with three entries in flight, then refill
    for (int i = 0; i < 3; i++) begin
      d3_in_valid = 1'b1; d3_in_data = 32'h21 + 32'(i); d3_in_ctrl = 8'h60;
      step();
    end
    d3_in_valid = 1'b0;
    check("t5_full_sv", d3_slice_valid, 3'b111);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", d3_out_valid, 1'b0);
    check("t5_rst_sv", d3_slice_valid, 3'b000);
    check("t5_rst_cnt", d3_bubble_cnt, 16'd0);
    check("t5_rst_ctrl", d3_out_ctrl, 8'h00);
    #2;
    rst = 1'b0;
    d3_in_valid = 1'b1; d3_in_data = 32'h99; d3_in_ctrl = 8'h42;
    step();
    d3_in_valid = 1'b0; d3_in_data = '0; d3_in_ctrl = '0;
    step();
    check("t5_refill_early", d3_out_valid, 1'b0);
    step();
    check("t5_refill_valid", d3_out_valid, 1'b1);
    check("t5_refill_data", d3_out_data, 32'h99);
    check("t5_refill_ctrl", d3_out_ctrl, 8'h42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
